car_passage_detector: RTL

- Direction-decoding FSM between the sensor debouncers and the 3-bit occupancy counter.
- Consumes the cleaned, active-high two-sensor vector and tracks the full gate sequence of one vehicle.
- Emits one-cycle car_in / car_out pulses that drive the counter's enable and up/down inputs.
- Flags illegal sequences and stalled passages so a sensor glitch or a parked car never miscounts.

---
 rtl/car_passage_detector.sv | 63 ++++++
 1 files changed

// File: rtl/car_passage_detector.sv
// car_passage_detector: decodes A/B gate sensor sequences into car_in/car_out pulses.
// Define PASSAGE_TIMEOUT_EN to abandon passages stalled in one intermediate state.
module car_passage_detector #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ab,
    output logic       car_in,
    output logic       car_out,
    output logic       err,
    output logic       timeout,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR} state_t;
    state_t state, legal_nxt, state_nxt;
    logic expire;
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    always_comb begin
        legal_nxt = state;
        case (state)
            IDLE: legal_nxt = ab == 2'b10 ? EN1 : ab == 2'b01 ? EX1 : ab == 2'b11 ? ERR : IDLE;
            EN1:  legal_nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? EN2 : ab == 2'b01 ? ERR : EN1;
            EN2:  legal_nxt = ab == 2'b10 ? EN1 : ab == 2'b01 ? EN3 : ab == 2'b00 ? ERR : EN2;
            EN3:  legal_nxt = ab == 2'b11 ? EN2 : ab == 2'b00 ? IDLE : ab == 2'b10 ? ERR : EN3;
            EX1:  legal_nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? EX2 : ab == 2'b10 ? ERR : EX1;
            EX2:  legal_nxt = ab == 2'b01 ? EX1 : ab == 2'b10 ? EX3 : ab == 2'b00 ? ERR : EX2;
            EX3:  legal_nxt = ab == 2'b11 ? EX2 : ab == 2'b00 ? IDLE : ab == 2'b01 ? ERR : EX3;
            default: legal_nxt = ab == 2'b00 ? IDLE : ERR;
        endcase
        state_nxt = expire ? ERR : legal_nxt;
    end
`ifdef PASSAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    // Only a held intermediate state can expire; any transition on that edge wins.
    assign expire = legal_nxt == state && state != IDLE && state != ERR &&
                    cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        cnt <= (reset || state_nxt != state || state == IDLE || state == ERR) ? '0 : cnt + 1'b1;
`else
    assign expire = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            car_in  <= 1'b0;
            car_out <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            car_in  <= state == EN3 && state_nxt == IDLE;
            car_out <= state == EX3 && state_nxt == IDLE;
            err     <= state_nxt == ERR && state != ERR && !expire;
            timeout <= expire;
            busy    <= state_nxt != IDLE;
        end
    end
endmodule
